aib_rx_word_aligner: RTL

AIB_RX_WORD_ALIGNER -- requirements
Module: aib_rx_word_aligner

---
 rtl/aib_align_pkg.sv | 34 +++
 rtl/aib_rx_sync_fifo.sv | 66 ++++++
 rtl/aib_rx_word_aligner.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/aib_align_pkg.sv
// Shared definitions for the AIB receive word aligner.
// Marker positions, payload geometry and the aligner FSM state type.
package aib_align_pkg;

  localparam int RAW_W   = 80;
  localparam int HALF_W  = 40;
  localparam int PAY_W   = 78;
  localparam int MARK_HI = 79;
  localparam int MARK_LO = 39;

  localparam logic MARK_HI_VAL = 1'b1;
  localparam logic MARK_LO_VAL = 1'b0;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } align_state_t;

  function automatic logic marker_ok(
    input logic [RAW_W-1:0] w
  );
    return (w[MARK_HI] == MARK_HI_VAL)
        && (w[MARK_LO] == MARK_LO_VAL);
  endfunction

  function automatic logic [PAY_W-1:0] strip(
    input logic [RAW_W-1:0] w
  );
    return {w[MARK_HI-1:MARK_LO+1],
            w[MARK_LO-1:0]};
  endfunction

endpackage

// File: rtl/aib_rx_sync_fifo.sv
// Synchronous FIFO with a registered read port.
// A word written at one edge becomes visible at the following edge.
module aib_rx_sync_fifo #(
  parameter int WIDTH = 78,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    count;
  logic [CW-1:0]    remain;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & rd_valid;
  assign push_ok = push & (~full | pop_ok);

  assign rd_ptr_n = rd_ptr + AW'(pop_ok);
  assign remain   = count - CW'(pop_ok);

  // Storage write; the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  // The head is taken from entries that existed before this edge,
  // so a freshly written word never bypasses to the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr   <= rd_ptr_n;
      count    <= count + CW'(push_ok) - CW'(pop_ok);
      rd_valid <= (remain != '0);
      rd_data  <= (remain != '0) ? mem[rd_ptr_n] : '0;
    end
  end

endmodule

// File: rtl/aib_rx_word_aligner.sv
// AIB receive word aligner: finds the 40-bit slip via marker bits,
// locks after repeated good markers and buffers stripped payloads.
module aib_rx_word_aligner
  import aib_align_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [79:0]  rx_data,
  input  logic         rx_en,
  input  logic         align_en,
  output logic [77:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         locked,
  output logic [15:0]  align_err_cnt,
  output logic         fifo_ovf
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  align_state_t     state_q, state_d;
  logic             offset_q, offset_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [15:0]      err_q, err_d;
  logic [RAW_W-1:0] prev_q;
  logic             ovf_q;
  logic [RAW_W-1:0] cand;
  logic             cand_good;
  logic             push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  assign cand = offset_q
    ? {rx_data[HALF_W-1:0], prev_q[RAW_W-1:HALF_W]}
    : rx_data;
  assign cand_good = marker_ok(cand);

  // Next-state, counter and push decisions for the alignment FSM.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    good_d   = good_q;
    bad_d    = bad_q;
    err_d    = err_q;
    push     = 1'b0;
    if (!align_en) begin
      state_d = ST_SEARCH;
      good_d  = '0;
      bad_d   = '0;
    end else if (rx_en) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (cand_good) begin
            if (LOCK_CNT <= 1) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              state_d = ST_VERIFY;
              good_d  = GW'(1);
            end
          end else begin
            offset_d = ~offset_q;
          end
        end
        ST_VERIFY: begin
          if (!cand_good) begin
            state_d  = ST_SEARCH;
            offset_d = ~offset_q;
            good_d   = '0;
          end else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
        ST_LOCKED: begin
          push = 1'b1;
          if (cand_good) begin
            bad_d = '0;
          end else begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (bad_q == BW'(UNLOCK_CNT - 1)) begin
              state_d = ST_SEARCH;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      offset_q <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
    end
  end

  assign fifo_pop = out_ready & ~fifo_empty;
  assign drop     = push & fifo_full & ~(fifo_pop & out_valid);

  // Previous raw word for the slipped candidate, and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (rx_en) begin
        prev_q <= rx_data;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  aib_rx_sync_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_data  (strip(cand)),
    .pop      (fifo_pop),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign locked        = (state_q == ST_LOCKED);
  assign align_err_cnt = err_q;
  assign fifo_ovf      = ovf_q;

endmodule
